// File: rtl/serial_adder.sv
// serial_adder: multi-cycle WIDTH-bit adder/subtractor that processes DIGIT
// bits per clock through one ripple slice and a registered carry.
// Each operation takes STEPS = WIDTH/DIGIT cycles.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   in_valid/in_ready input handshake for operands a, b, cin, sub
//   a, b              WIDTH-bit operands
//   cin               carry-in
//   sub               1 = a + ~b + carry-in adjust (a - b for cin = 0)
//   out_valid/out_ready output handshake for sum, cout
//   sum               WIDTH-bit result (modulo 2^WIDTH)
//   cout              carry out of the MSB (subtract: 1 = no borrow)
//   ovf               signed overflow, present only with SERIAL_ADDER_OVF_EN
//
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the registered ovf output.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("serial_adder: WIDTH must be at least 2");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_adder: DIGIT must divide WIDTH exactly");
    end
  endgenerate

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CW-1:0]    count;
  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] sum_next;
  logic             accept;
  logic             last_step;

  always_comb begin
    in_ready = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
    accept   = in_valid & in_ready;
    last_step = (count == LAST);
    slice = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]}
          + {{DIGIT{1'b0}}, carry};
    // Result fills LSB-first: each new digit enters at the top and the
    // register shifts right, so after STEPS digits the word is aligned.
    sum_next = sum >> DIGIT;
    sum_next[WIDTH-1 -: DIGIT] = slice[DIGIT-1:0];
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Carry into the MSB recovered from the MSB's own sum bit and inputs.
  logic msb_cin;
  always_comb begin
    msb_cin = slice[DIGIT-1] ^ op_a[DIGIT-1] ^ op_b[DIGIT-1];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      count     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (accept) begin
      // Covers both IDLE and the zero-bubble DONE->RUN hand-over.
      op_a      <= a;
      op_b      <= sub ? ~b : b;
      carry     <= cin ^ sub;
      count     <= '0;
      out_valid <= 1'b0;
      state     <= RUN;
    end else if (state == RUN) begin
      op_a  <= op_a >> DIGIT;
      op_b  <= op_b >> DIGIT;
      carry <= slice[DIGIT];
      sum   <= sum_next;
      count <= count + 1'b1;
      if (last_step) begin
        state     <= DONE;
        out_valid <= 1'b1;
        cout      <= slice[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
        ovf       <= msb_cin ^ slice[DIGIT];
`endif
      end
    end else if (state == DONE) begin
      if (out_ready) begin
        out_valid <= 1'b0;
        state     <= IDLE;
      end
    end else if (state != IDLE) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder: three instances
// (16/1, 16/4, 8/8) share clock and reset.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [2:0]  iv, ordy, cinv, subv;
  logic [2:0]  irdy, ov, co, of;
  logic [15:0] av [3];
  logic [15:0] bv [3];
  logic [15:0] sm [3];
  logic [7:0]  sm8;

  assign sm[2] = {8'h00, sm8};

  serial_adder #(.WIDTH(16), .DIGIT(1)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(av[0]), .b(bv[0]), .cin(cinv[0]), .sub(subv[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm[0]), .cout(co[0])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(of[0])
`endif
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(av[1]), .b(bv[1]), .cin(cinv[1]), .sub(subv[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm[1]), .cout(co[1])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(of[1])
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
    .a(av[2][7:0]), .b(bv[2][7:0]), .cin(cinv[2]), .sub(subv[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sm8), .cout(co[2])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(of[2])
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign of = '0;
`endif

  // Drives one operation on instance sel and returns what came out,
  // the accept-to-out_valid latency in cycles, and whether in_ready was up.
  task automatic do_op(input int sel, input logic [15:0] a_i, input logic [15:0] b_i,
                       input logic c_i, input logic s_i,
                       output logic [15:0] s_o, output logic c_o, output logic o_o,
                       output int lat, output logic rdy);
    av[sel] = a_i; bv[sel] = b_i; cinv[sel] = c_i; subv[sel] = s_i;
    iv[sel] = 1'b1;
    #1;
    rdy = irdy[sel];
    @(posedge clk); #1;
    iv[sel] = 1'b0;
    lat = 0;
    while (!ov[sel] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    s_o = sm[sel]; c_o = co[sel]; o_o = of[sel];
    ordy[sel] = 1'b1;
    @(posedge clk); #1;
    ordy[sel] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv = '0; ordy = '0; cinv = '0; subv = '0;
    for (int i = 0; i < 3; i++) begin av[i] = '0; bv[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irdy !== 3'b000) begin failures++; $display("FAIL reset_in_ready got=%b want=000", irdy); end
    checks++;
    if (ov !== 3'b000) begin failures++; $display("FAIL reset_out_valid got=%b want=000", ov); end
    checks++;
    if (sm[0] !== 16'h0000 || co[0] !== 1'b0) begin
      failures++; $display("FAIL reset_sum got=%h/%b want=0000/0", sm[0], co[0]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (irdy !== 3'b111) begin failures++; $display("FAIL idle_in_ready got=%b want=111", irdy); end
  endtask

  task automatic test_add();
    logic [15:0] s; logic c, o, r; int lat;
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat, r);
    checks++;
    if (s !== 16'h8000 || c !== 1'b0) begin
      failures++; $display("FAIL add_7fff got=%h/%b want=8000/0", s, c);
    end
    checks++;
    if (lat !== 16) begin failures++; $display("FAIL add_latency got=%0d want=16", lat); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (o !== 1'b1) begin failures++; $display("FAIL add_7fff_ovf got=%b want=1", o); end
`endif
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat, r);
    checks++;
    if (s !== 16'h0000 || c !== 1'b1) begin
      failures++; $display("FAIL add_ffff got=%h/%b want=0000/1", s, c);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (o !== 1'b0) begin failures++; $display("FAIL add_ffff_ovf got=%b want=0", o); end
`endif
    do_op(0, 16'h1000, 16'h0234, 1'b1, 1'b0, s, c, o, lat, r);
    checks++;
    if (s !== 16'h1235 || c !== 1'b0) begin
      failures++; $display("FAIL add_cin got=%h/%b want=1235/0", s, c);
    end
  endtask

  task automatic test_sub();
    logic [15:0] s; logic c, o, r; int lat;
    do_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, s, c, o, lat, r);
    checks++;
    if (s !== 16'hFFFE || c !== 1'b0) begin
      failures++; $display("FAIL sub_borrow got=%h/%b want=fffe/0", s, c);
    end
    do_op(0, 16'h0007, 16'h0005, 1'b0, 1'b1, s, c, o, lat, r);
    checks++;
    if (s !== 16'h0002 || c !== 1'b1) begin
      failures++; $display("FAIL sub_noborrow got=%h/%b want=0002/1", s, c);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    av[0] = 16'h1234; bv[0] = 16'h0001; cinv[0] = 1'b0; subv[0] = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (sm[0] !== 16'h1235 || ov[0] !== 1'b1) begin
      failures++; $display("FAIL bp_first got=%h/%b want=1235/1", sm[0], ov[0]);
    end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (sm[0] !== 16'h1235 || ov[0] !== 1'b1 || irdy[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL bp_hold got=%0d_bad_cycles want=0 (sum=%h ov=%b rdy=%b)", bad, sm[0], ov[0], irdy[0]);
    end
    ordy[0] = 1'b1; iv[0] = 1'b1; av[0] = 16'h0100; bv[0] = 16'h0200;
    #1;
    checks++;
    if (irdy[0] !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b want=1", irdy[0]); end
    @(posedge clk); #1;
    iv[0] = 1'b0; ordy[0] = 1'b0;
    checks++;
    if (ov[0] !== 1'b0 || irdy[0] !== 1'b0) begin
      failures++; $display("FAIL b2b_run got=ov%b/rdy%b want=ov0/rdy0", ov[0], irdy[0]);
    end
    lat = 0;
    while (!ov[0] && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (sm[0] !== 16'h0300 || lat !== 16) begin
      failures++; $display("FAIL b2b_result got=%h lat=%0d want=0300 lat=16", sm[0], lat);
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] s; logic c, o, r; int lat; int seen;
    av[0] = 16'h0F0F; bv[0] = 16'h0101; cinv[0] = 1'b0; subv[0] = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov[0] !== 1'b0 || sm[0] !== 16'h0000 || irdy[0] !== 1'b0) begin
      failures++; $display("FAIL midrst_state got=ov%b sum%h rdy%b want=ov0 sum0000 rdy0", ov[0], sm[0], irdy[0]);
    end
    rst = 1'b0;
    #1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (ov[0] !== 1'b0 || irdy[0] !== 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL midrst_idle got=%0d_bad_cycles want=0", seen); end
    do_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, s, c, o, lat, r);
    checks++;
    if (s !== 16'h2345 || c !== 1'b0 || r !== 1'b1) begin
      failures++; $display("FAIL midrst_newop got=%h/%b rdy%b want=2345/0 rdy1", s, c, r);
    end
  endtask

  task automatic test_digit4();
    logic [15:0] s; logic c, o, r; int lat;
    do_op(1, 16'hABCD, 16'h1234, 1'b0, 1'b0, s, c, o, lat, r);
    checks++;
    if (s !== 16'hBE01 || c !== 1'b0) begin
      failures++; $display("FAIL d4_sum got=%h/%b want=be01/0", s, c);
    end
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL d4_latency got=%0d want=4", lat); end
    do_op(1, 16'h8000, 16'h8000, 1'b1, 1'b0, s, c, o, lat, r);
    checks++;
    if (s !== 16'h0001 || c !== 1'b1) begin
      failures++; $display("FAIL d4_carry got=%h/%b want=0001/1", s, c);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (o !== 1'b1) begin failures++; $display("FAIL d4_ovf got=%b want=1", o); end
`endif
  endtask

  task automatic test_digit8();
    logic [15:0] s; logic c, o, r; int lat;
    do_op(2, 16'h00C8, 16'h0064, 1'b0, 1'b0, s, c, o, lat, r);
    checks++;
    if (s !== 16'h002C || c !== 1'b1) begin
      failures++; $display("FAIL d8_sum got=%h/%b want=002c/1", s, c);
    end
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL d8_latency got=%0d want=1", lat); end
    do_op(2, 16'h0070, 16'h0020, 1'b0, 1'b0, s, c, o, lat, r);
    checks++;
    if (s !== 16'h0090 || c !== 1'b0) begin
      failures++; $display("FAIL d8_sum2 got=%h/%b want=0090/0", s, c);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (o !== 1'b1) begin failures++; $display("FAIL d8_ovf got=%b want=1", o); end
`endif
    do_op(2, 16'h0010, 16'h0003, 1'b0, 1'b1, s, c, o, lat, r);
    checks++;
    if (s !== 16'h000D || c !== 1'b1) begin
      failures++; $display("FAIL d8_sub got=%h/%b want=000d/1", s, c);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_digit4();
    test_digit8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
